mem_port_arbiter: RTL

//  Shares one RAMHelper-style single-port memory between the core's icache (read-only)
//  and dcache (read/write) cmd/rsp interfaces. It sits between the core and the

---
 rtl/mem_port_arbiter.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Shares one single-port RAM between icache (read) and dcache (r/w); dcache wins unless icache starves.
// 1-cycle read latency, responses cannot be backpressured; perf counters exist only with MEM_ARB_PERF_EN.
module mem_port_arbiter #(
    parameter int                ADDR_W       = 64,
    parameter int                IDX_W        = 28,
    parameter logic [ADDR_W-1:0] BASE_ADDR    = ADDR_W'(64'h8000_0000),
    parameter int                STARVE_LIMIT = 4,
    parameter int                CNT_W        = 32
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              icache_cmd_valid,
    output logic              icache_cmd_ready,
    input  logic [ADDR_W-1:0] icache_cmd_addr,
    output logic              icache_rsp_valid,
    output logic [31:0]       icache_rsp_data,
    input  logic              dcache_cmd_valid,
    output logic              dcache_cmd_ready,
    input  logic [ADDR_W-1:0] dcache_cmd_addr,
    input  logic              dcache_cmd_wen,
    input  logic [63:0]       dcache_cmd_wdata,
    input  logic [7:0]        dcache_cmd_wstrb,
    output logic              dcache_rsp_valid,
    output logic [63:0]       dcache_rsp_data,
    output logic              mem_en,
    output logic [IDX_W-1:0]  mem_idx,
    input  logic [63:0]       mem_rdata,
    output logic              mem_wen,
    output logic [63:0]       mem_wdata,
    output logic [63:0]       mem_wmask,
    output logic              addr_err,
    input  logic              perf_clean,
    output logic [CNT_W-1:0]  perf_igrant_cnt,
    output logic [CNT_W-1:0]  perf_dgrant_cnt,
    output logic [CNT_W-1:0]  perf_conflict_cnt
);

    localparam int SC_W = $clog2(STARVE_LIMIT + 1);

    typedef enum logic {NORMAL, FORCE_I} state_t;

    state_t            state, state_next;
    logic [SC_W-1:0]   starve_cnt, starve_next;
    logic              icache_grant, dcache_grant, fire_any, in_win;
    logic [ADDR_W-1:0] sel_addr, offset;
    logic [63:0]       rdata_ok;

    always_comb begin
        state_next   = state;
        starve_next  = '0;
        icache_grant = 1'b0;
        dcache_grant = 1'b0;
        case (state)
            NORMAL: begin
                dcache_grant = dcache_cmd_valid;
                icache_grant = icache_cmd_valid & ~dcache_cmd_valid;
            end
            FORCE_I: icache_grant = icache_cmd_valid;
            default: ;
        endcase
        if (reset) begin
            icache_grant = 1'b0;
            dcache_grant = 1'b0;
        end
        if (icache_cmd_valid && !icache_grant)
            starve_next = starve_cnt + 1'b1;
        // Entering FORCE_I on the count reaching the limit makes the next cycle the icache's.
        case (state)
            NORMAL:  if (starve_next == SC_W'(STARVE_LIMIT)) state_next = FORCE_I;
            FORCE_I: if (icache_grant || !icache_cmd_valid) state_next = NORMAL;
            default: state_next = NORMAL;
        endcase
    end

    assign icache_cmd_ready = icache_grant;
    assign dcache_cmd_ready = dcache_grant;
    assign fire_any         = icache_grant | dcache_grant;
    assign sel_addr         = dcache_grant ? dcache_cmd_addr : icache_cmd_addr;
    assign offset           = sel_addr - BASE_ADDR;
    assign in_win           = (sel_addr >= BASE_ADDR) && ((offset >> (IDX_W + 3)) == '0);

    assign mem_en    = fire_any & in_win;
    assign mem_idx   = IDX_W'(offset >> 3);
    assign mem_wen   = dcache_grant & dcache_cmd_wen & in_win;
    assign mem_wdata = dcache_cmd_wdata;
    assign rdata_ok  = in_win ? mem_rdata : 64'd0;

    for (genvar i = 0; i < 8; i++) begin : g_mask
        assign mem_wmask[8*i +: 8] = {8{dcache_cmd_wstrb[i]}};
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state            <= NORMAL;
            starve_cnt       <= '0;
            icache_rsp_valid <= 1'b0;
            icache_rsp_data  <= '0;
            dcache_rsp_valid <= 1'b0;
            dcache_rsp_data  <= '0;
            addr_err         <= 1'b0;
        end else begin
            state            <= state_next;
            starve_cnt       <= starve_next;
            icache_rsp_valid <= icache_grant;
            dcache_rsp_valid <= dcache_grant & ~dcache_cmd_wen;
            if (icache_grant)
                icache_rsp_data <= sel_addr[2] ? rdata_ok[63:32] : rdata_ok[31:0];
            if (dcache_grant && !dcache_cmd_wen)
                dcache_rsp_data <= rdata_ok;
            if (fire_any && !in_win)
                addr_err <= 1'b1;
        end
    end

`ifdef MEM_ARB_PERF_EN
    logic [CNT_W-1:0] igrant_cnt, dgrant_cnt, conflict_cnt;

    always_ff @(posedge clock) begin
        if (reset || perf_clean) begin
            igrant_cnt   <= '0;
            dgrant_cnt   <= '0;
            conflict_cnt <= '0;
        end else begin
            if (icache_grant && igrant_cnt != '1)
                igrant_cnt <= igrant_cnt + 1'b1;
            if (dcache_grant && dgrant_cnt != '1)
                dgrant_cnt <= dgrant_cnt + 1'b1;
            if (icache_cmd_valid && dcache_cmd_valid && conflict_cnt != '1)
                conflict_cnt <= conflict_cnt + 1'b1;
        end
    end

    assign perf_igrant_cnt   = igrant_cnt;
    assign perf_dgrant_cnt   = dgrant_cnt;
    assign perf_conflict_cnt = conflict_cnt;
`else
    logic unused_perf_clean;
    assign unused_perf_clean = perf_clean;
    assign perf_igrant_cnt   = '0;
    assign perf_dgrant_cnt   = '0;
    assign perf_conflict_cnt = '0;
`endif

endmodule
